// File: rtl/mux_scan_seq.sv
// Registered N:1 channel selector with manual select, round-robin AUTO scan,
// single-sweep scan with per-channel dwell, and a HOLD mode that freezes the output.
module mux_scan_seq #(
  parameter int N_CH  = 16,
  parameter int DW    = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   din,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic                 start,
  output logic [DW-1:0]        dout,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 sweep_done
);

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(N_CH - 1);

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_AUTO   = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0]  sel_out_q, sel_out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              last_dwell, last_ch;

  // Indices past the last channel read as zero rather than X.
  function automatic logic [DW-1:0] ch_read(input logic [SEL_W-1:0] idx,
                                            input logic [N_CH*DW-1:0] bus);
    ch_read = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) ch_read = bus[k*DW +: DW];
    end
  endfunction

  assign last_dwell = (dcnt_q == DCNT_LAST);
  assign last_ch    = (ptr_q == PTR_LAST);

  always_comb begin
    state_d      = S_IDLE;
    dout_d       = dout_q;
    sel_out_d    = sel_out_q;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    sweep_done_d = 1'b0;
    ptr_d        = ptr_q;
    dcnt_d       = dcnt_q;

    case (mode)
      M_MANUAL: begin
        dout_d    = ch_read(sel_in, din);
        sel_out_d = sel_in;
        valid_d   = 1'b1;
        ptr_d     = '0;
        dcnt_d    = '0;
      end
      M_AUTO, M_SWEEP: begin
        if (mode == M_SWEEP && state_q == S_IDLE) begin
          ptr_d  = '0;
          dcnt_d = '0;
          if (start) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end else begin
          // Shared scan step: sample on the first clock of each dwell window.
          if (dcnt_q == '0) begin
            dout_d    = ch_read(ptr_q, din);
            sel_out_d = ptr_q;
            valid_d   = 1'b1;
          end
          if (last_dwell) begin
            dcnt_d = '0;
            ptr_d  = last_ch ? '0 : ptr_q + 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
          if (mode == M_SWEEP) begin
            if (last_ch && last_dwell) begin
              sweep_done_d = 1'b1;
            end else begin
              state_d = S_RUN;
              busy_d  = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dout_q       <= '0;
      sel_out_q    <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      ptr_q        <= '0;
      dcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      sel_out_q    <= sel_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      ptr_q        <= ptr_d;
      dcnt_q       <= dcnt_d;
    end
  end

  assign dout       = dout_q;
  assign sel_out    = sel_out_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule
